// File: rtl/ttm_stack_pkg.sv
`default_nettype none
// ============================================================================
// ttm_stack_pkg : shared types and helpers for the TTM4 hardware stack
// Revision 1.0
// ============================================================================
package ttm_stack_pkg;

  localparam int WRAP_DISCARD  = 0;
  localparam int WRAP_CIRCULAR = 1;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stackOp_t;

  // Both strobes low together means replace-top, not a conflict.
  function automatic stackOp_t decodeOp(input logic nPush, input logic nPop);
    stackOp_t op;
    case ({nPush, nPop})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b00:   op = OP_REPLACE;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ttm_stack_mem.sv
`default_nettype none
// ============================================================================
// ttm_stack_mem : DEPTH x DATA_W register file, 1 sync write, 2 async reads
// Revision 1.0
// ============================================================================
module ttm_stack_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [PTR_W-1:0]  wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [PTR_W-1:0]  topAddr,
  output logic [DATA_W-1:0] topData,
  input  logic [PTR_W-1:0]  rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign topData = mem[topAddr];
  assign rdData  = mem[rdAddr];

endmodule
`default_nettype wire

// File: rtl/ttm_stack_unit.sv
`default_nettype none
// ============================================================================
// ttm_stack_unit : parametrised stack with pointer, storage, flags, debug read
// Revision 1.0
// ============================================================================
module ttm_stack_unit
  import ttm_stack_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = WRAP_DISCARD,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              nCLR,
  input  logic              nPUSH,
  input  logic              nPOP,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] TOP,
  output logic [PTR_W:0]    COUNT,
  output logic              EMPTY,
  output logic              FULL,
  output logic              OVF,
  output logic              UNF,
  input  logic [PTR_W-1:0]  RD_IDX,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_OOR
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  wrPtr, wrPtrNext;
  logic [PTR_W:0]    cnt, cntNext;
  logic              ovfFlag, ovfNext;
  logic              unfFlag, unfNext;

  stackOp_t          op;
  logic              isEmpty, isFull, pushReq;
  logic              memWrEn;
  logic [PTR_W-1:0]  memWrAddr;
  logic [PTR_W-1:0]  topPtr, rdPtr;
  logic [DATA_W-1:0] memTop, memRd;

  assign op      = decodeOp(nPUSH, nPOP);
  assign isEmpty = (cnt == '0);
  assign isFull  = (cnt == FULL_CNT);
  assign topPtr  = wrPtr - 1'b1;
  assign rdPtr   = wrPtr - 1'b1 - RD_IDX;
  // Replace on an empty stack has nothing to overwrite, so it degrades to a push.
  assign pushReq = (op == OP_PUSH) || ((op == OP_REPLACE) && isEmpty);

  always_comb begin
    wrPtrNext = wrPtr;
    cntNext   = cnt;
    ovfNext   = ovfFlag;
    unfNext   = unfFlag;
    memWrEn   = 1'b0;
    memWrAddr = wrPtr;
    if (!nCLR) begin
      wrPtrNext = '0;
      cntNext   = '0;
      ovfNext   = 1'b0;
      unfNext   = 1'b0;
    end else if (pushReq) begin
      if (!isFull) begin
        memWrEn   = 1'b1;
        wrPtrNext = wrPtr + 1'b1;
        cntNext   = cnt + 1'b1;
      end else begin
        ovfNext = 1'b1;
        if (WRAP_MODE == WRAP_CIRCULAR) begin
          memWrEn   = 1'b1;
          wrPtrNext = wrPtr + 1'b1;
        end
      end
    end else if (op == OP_POP) begin
      if (isEmpty) begin
        unfNext = 1'b1;
      end else begin
        wrPtrNext = wrPtr - 1'b1;
        cntNext   = cnt - 1'b1;
      end
    end else if (op == OP_REPLACE) begin
      memWrEn   = 1'b1;
      memWrAddr = topPtr;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wrPtr   <= '0;
      cnt     <= '0;
      ovfFlag <= 1'b0;
      unfFlag <= 1'b0;
    end else begin
      wrPtr   <= wrPtrNext;
      cnt     <= cntNext;
      ovfFlag <= ovfNext;
      unfFlag <= unfNext;
    end
  end

  ttm_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) uMem (
    .clk     (CLK),
    .wrEn    (memWrEn & RST),
    .wrAddr  (memWrAddr),
    .wrData  (DIN),
    .topAddr (topPtr),
    .topData (memTop),
    .rdAddr  (rdPtr),
    .rdData  (memRd)
  );

  assign RD_OOR  = ({1'b0, RD_IDX} >= cnt);
  assign TOP     = isEmpty ? '0 : memTop;
  assign RD_DATA = RD_OOR ? '0 : memRd;
  assign COUNT   = cnt;
  assign EMPTY   = isEmpty;
  assign FULL    = isFull;
  assign OVF     = ovfFlag;
  assign UNF     = unfFlag;

endmodule
`default_nettype wire

// File: doc/ttm_stack_unit.md
Name: ttm_stack_unit

Overview:
Parametrised hardware stack, the successor to the fixed 8-bit stack pointer in the TTM4 core. It owns both the pointer and the storage, so CALL/RET return addresses and PUSH/POP data live inside the block. Width, depth and overflow policy are configurable. It adds features the old pointer lacks: replace-top, full/empty, sticky error flags, occupancy count and an indexed debug read port.

Parameters:
DATA_W, 8, width of each stack entry (8 holds a TTM4 program address).
DEPTH, 16, number of entries; must be a power of two and at least 2.
WRAP_MODE, 0, overflow policy: 0 = push to a full stack is discarded; 1 = circular, the oldest entry is overwritten.
PTR_W, $clog2(DEPTH), derived pointer width; not overridden.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  reset, asynchronous, active-low.
nCLR  in  1  synchronous clear, active-low; highest priority after RST.
nPUSH  in  1  push request, active-low.
nPOP  in  1  pop request, active-low.
DIN  in  DATA_W  data to push or replace.
TOP  out  DATA_W  current top-of-stack entry; 0 when EMPTY.
COUNT  out  PTR_W+1  number of valid entries, 0..DEPTH.
EMPTY  out  1  high when COUNT=0.
FULL  out  1  high when COUNT=DEPTH.
OVF  out  1  sticky overflow flag.
UNF  out  1  sticky underflow flag.
RD_IDX  in  PTR_W  debug read index; 0 = top, 1 = next below, and so on.
RD_DATA  out  DATA_W  entry at RD_IDX; 0 if RD_IDX >= COUNT.
RD_OOR  out  1  high when RD_IDX >= COUNT.

Behaviour:
- State: write pointer WP (PTR_W bits, wraps modulo DEPTH), count CNT, flags OVF and UNF, and the entry array.
- Reset (RST=0, asynchronous): WP=0, CNT=0, OVF=0, UNF=0. Outputs then read TOP=0, COUNT=0, EMPTY=1, FULL=0, RD_DATA=0, RD_OOR=1. Array contents are don't-care.
- Operations are decoded from {nPUSH,nPOP} on each rising edge, with nCLR=1:
  - 11 = NOP: no change.
  - 01 = PUSH.
  - 10 = POP.
  - 00 = REPLACE.
- PUSH when not full: mem[WP]<=DIN; WP<=WP+1; CNT<=CNT+1.
- PUSH when full, WRAP_MODE=0: no state change except OVF<=1.
- PUSH when full, WRAP_MODE=1: mem[WP]<=DIN; WP<=WP+1 (wraps); CNT stays DEPTH; OVF<=1. The oldest entry is lost.
- POP when not empty: WP<=WP-1 (modulo DEPTH); CNT<=CNT-1. Data is not returned on this edge; it was already visible on TOP before the edge.
- POP when empty: no state change except UNF<=1.
- REPLACE when not empty: mem[WP-1]<=DIN; WP and CNT unchanged. This implements RET+CALL style tail replacement in one cycle.
- REPLACE when empty: behaves exactly as PUSH; UNF is not set.
- nCLR=0 on an edge: WP=0, CNT=0, OVF=0, UNF=0. Any simultaneous push or pop is ignored.
- OVF and UNF stay set until reset or nCLR. No operation clears them.
- Output timing:
  - TOP = mem[WP-1] when CNT>0, else 0. It is combinational from registered state, so TOP reflects the post-edge state with zero added latency. A value pushed at edge k appears on TOP after edge k.
  - RD_DATA = mem[WP-1-RD_IDX] (modulo DEPTH) when RD_IDX<CNT, else 0. Combinational.
  - EMPTY, FULL and COUNT are decoded from CNT. No glitch-free guarantee is given on combinational outputs.
- Arithmetic: all pointer arithmetic is modulo DEPTH. CNT never exceeds DEPTH and never goes below 0.
- Reset mid-operation: asynchronous assertion immediately forces the reset values. Release is sampled on the next edge; no operation executes on the edge where RST is still low.

Decomposition:
- Package ttm_stack_pkg holds:
  - the op enum {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE};
  - the function decoding {nPUSH,nPOP} into that enum;
  - localparam WRAP_DISCARD=0, WRAP_CIRCULAR=1.
- Sub-module ttm_stack_mem is a DEPTH x DATA_W register file with:
  - one synchronous write port (no reset on the array);
  - two asynchronous read ports, one for TOP and one for RD_DATA.
- The top level holds WP/CNT/flag control and the output muxing.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 -> TOP=0x33, COUNT=3, EMPTY=0; pop twice -> TOP=0x11, COUNT=1.
- WRAP_MODE=0, DEPTH=4: push 1..5 -> COUNT=4, FULL=1, OVF=1, TOP=4; pop 4 times -> values 4,3,2,1 seen on TOP in order; fifth pop -> UNF=1, COUNT=0.
- WRAP_MODE=1, DEPTH=4: push 1..6 -> COUNT=4, OVF=1; RD_IDX 0..3 -> 6,5,4,3; RD_IDX=3 after one pop -> RD_OOR=1, RD_DATA=0.
- REPLACE: push 0xA0, then nPUSH=nPOP=0 with DIN=0xB0 -> TOP=0xB0, COUNT=1; REPLACE on empty with DIN=0xC0 -> COUNT=1, TOP=0xC0, UNF=0.
- Set OVF and UNF, then drive nCLR=0 together with nPUSH=0 -> COUNT=0, flags 0, push ignored.
- After 3 pushes, assert RST low between edges -> COUNT=0, EMPTY=1 and TOP=0 immediately, before the next clock edge.
